// File: rtl/four_count_pkg.sv
// ============================================================================
// four_count_pkg : state encoding and widths shared by the modulo-4 counter
// Rev 1.0
// ============================================================================
`default_nettype none

package four_count_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  localparam int OUT_W = 4;

endpackage

`default_nettype wire

// File: rtl/four_count_decode.sv
// ============================================================================
// four_count_decode : one-hot view and terminal flag of a 2-bit count
// Rev 1.0
// ============================================================================
`default_nettype none

module four_count_decode
  import four_count_pkg::*;
(
  input  state_t           state,
  output logic [OUT_W-1:0] out,
  output logic             z
);

  always_comb begin
    out = 4'b0001;
    z   = 1'b0;
    case (state)
      S0: out = 4'b0001;
      S1: out = 4'b0010;
      S2: out = 4'b0100;
      S3: begin
        out = 4'b1000;
        z   = 1'b1;
      end
      // A corrupt code reads as S0 so the output never goes zero or multi-hot.
      default: begin
        out = 4'b0001;
        z   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/four_count.sv
// ============================================================================
// four_count : modulo-4 counter of cycles with x high, one-hot out, z at 3
// Rev 1.0
// ============================================================================
`default_nettype none

module four_count
  import four_count_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             x,
  output logic [OUT_W-1:0] out,
  output logic             z
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = x ? S1 : S0;
      S1:      state_d = x ? S2 : S1;
      S2:      state_d = x ? S3 : S2;
      S3:      state_d = x ? S0 : S3;
      default: state_d = S0;
    endcase
  end

  four_count_decode u_decode (
    .state (state_q),
    .out   (out),
    .z     (z)
  );

endmodule

`default_nettype wire

// File: tb/tb_four_count.sv
// ============================================================================
// tb_four_count : scoreboard bench for the modulo-4 counter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_four_count;

  logic       clock;
  logic       reset;
  logic       x;
  logic [3:0] out;
  logic       z;

  int checks = 0;
  int errors = 0;
  int count  = 0;

  typedef struct packed {
    logic [3:0] out;
    logic       z;
  } exp_t;

  exp_t sb_q[$];

  four_count dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .out   (out),
    .z     (z)
  );

  initial clock = 1'b0;
  always #20 clock = ~clock;

  function automatic exp_t model_exp(int c);
    exp_t e;
    e.out = 4'b0001 << c;
    e.z   = (c == 3);
    return e;
  endfunction

  task automatic chk(string name, logic [3:0] ao, logic az, exp_t e);
    checks++;
    if (ao !== e.out || az !== e.z) begin
      errors++;
      $display("FAIL %s: got out=%b z=%b, expected out=%b z=%b at %0t",
               name, ao, az, e.out, e.z, $time);
    end
  endtask

  // One x value spanning the next rising edge; expectation goes to the monitor.
  task automatic step(logic xv);
    @(negedge clock);
    x = xv;
    if (xv) count = (count + 1) % 4;
    sb_q.push_back(model_exp(count));
  endtask

  // Async reset pulse between edges, checked immediately, then x for the next edge.
  task automatic pulse_reset(logic xv);
    @(negedge clock);
    x = 1'b0;
    #5 reset = 1'b1;
    #1;
    chk("async_reset", out, z, model_exp(0));
    #4 reset = 1'b0;
    x = xv;
    count = xv ? 1 : 0;
    sb_q.push_back(model_exp(count));
  endtask

  // Monitor: compare after every rising edge for which an expectation exists.
  initial begin
    forever begin
      @(posedge clock);
      #5;
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("scoreboard", out, z, e);
        checks++;
        if (!$onehot(out)) begin
          errors++;
          $display("FAIL onehot: got out=%b, expected exactly one bit set", out);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    x     = 1'b0;
    #1;
    chk("reset_before_edge", out, z, model_exp(0));
    #30;
    chk("reset_after_edge", out, z, model_exp(0));
    #19 reset = 1'b0;

    // Single increments separated by idle cycles.
    repeat (4) begin
      step(1'b1);
      step(1'b0);
    end

    // Advance to S2 and hold there.
    step(1'b1);
    step(1'b1);
    repeat (5) step(1'b0);

    // Back to S0, then nine consecutive counts land in S1.
    step(1'b1);
    step(1'b1);
    repeat (9) step(1'b1);

    // Reset coincident with a rising edge while x=1 in S1.
    @(negedge clock);
    x = 1'b1;
    @(posedge clock);
    reset = 1'b1;
    #1;
    chk("reset_priority", out, z, model_exp(0));
    count = 0;
    @(negedge clock);
    reset = 1'b0;
    x     = 1'b0;

    // Reach S3, abort with an async reset, restart counting immediately.
    repeat (3) step(1'b1);
    pulse_reset(1'b1);

    repeat (400) begin
      if ($urandom_range(0, 19) == 0) pulse_reset(1'($urandom_range(0, 1)));
      else                            step(1'($urandom_range(0, 1)));
    end

    @(negedge clock);
    x = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
